tcbus_arb2: RTL and testbench

- Two-requester arbiter sharing one downstream TC bus port (req/rnw/addr/wdata with aack/rack/wack handshakes).
- Grants the bus round-robin and holds the grant until address acknowledge.
- Limits total outstanding transactions to MAX_PEND.
- Routes in-order read and write responses back to the originating requester using per-type ID queues.

---
 rtl/tcbus_pkg.sv | 16 +
 rtl/tcbus_arb2_if.sv | 16 +
 rtl/tcbus_id_fifo.sv | 53 +++++
 rtl/tcbus_arb2.sv | 149 ++++++++++++++
 tb/tb_tcbus_arb2.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcbus_pkg.sv
// Shared types and constants for the two-requester TC bus arbiter.
package tcbus_pkg;

   typedef logic owner_t;

   localparam owner_t RR_M0 = 1'b0;
   localparam owner_t RR_M1 = 1'b1;

   localparam int PEND_W = 3;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } arb_state_t;

endpackage

// File: rtl/tcbus_arb2_if.sv
// Downstream TC bus: arbiter drives request/address/data, target returns acknowledges.
interface tcbus_arb2_if #(
   parameter int TC_AWIDTH = 8,
   parameter int TC_DWIDTH = 8
);
   logic                 req;
   logic                 rnw;
   logic [TC_AWIDTH-1:0] addr;
   logic [TC_DWIDTH-1:0] wdata;
   logic                 aack;
   logic                 rack;
   logic                 wack;

   modport master (output req, rnw, addr, wdata, input aack, rack, wack);
   modport slave  (input req, rnw, addr, wdata, output aack, rack, wack);
endinterface

// File: rtl/tcbus_id_fifo.sv
// Requester-ID FIFO: one bit per outstanding transaction, head visible combinationally.
module tcbus_id_fifo
   import tcbus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  owner_t            din,
   input  logic              pop,
   output owner_t            head,
   output logic              empty,
   output logic [PEND_W-1:0] count
);

   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   owner_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/tcbus_arb2.sv
// Round-robin arbiter for two requesters onto one TC bus, with in-order response routing.
module tcbus_arb2
   import tcbus_pkg::*;
#(
   parameter int TC_AWIDTH = 8,
   parameter int TC_DWIDTH = 8,
   parameter int MAX_PEND  = 4
) (
   input  logic                 clk_bus,
   input  logic                 rst_n,
   input  logic                 m0_req,
   input  logic                 m0_rnw,
   input  logic [TC_AWIDTH-1:0] m0_addr,
   input  logic [TC_DWIDTH-1:0] m0_wdata,
   output logic                 m0_aack,
   output logic                 m0_rack,
   output logic                 m0_wack,
   input  logic                 m1_req,
   input  logic                 m1_rnw,
   input  logic [TC_AWIDTH-1:0] m1_addr,
   input  logic [TC_DWIDTH-1:0] m1_wdata,
   output logic                 m1_aack,
   output logic                 m1_rack,
   output logic                 m1_wack,
   tcbus_arb2_if.master         tc,
   output logic [PEND_W-1:0]    pend_cnt,
   output logic                 proto_err
);

   localparam logic [PEND_W-1:0] MAX_C = PEND_W'(MAX_PEND);

   arb_state_t state, state_nxt;
   owner_t     owner, owner_nxt;
   owner_t     rr_prio, rr_nxt;
   logic       gnt_vld;

   logic       sel_req, sel_rnw;
   logic       rd_aack, wr_aack;
   logic       rd_push, rd_pop, rd_byp, rd_hit, rd_empty;
   logic       wr_push, wr_pop, wr_byp, wr_hit, wr_empty;
   owner_t     rd_head, wr_head, rd_tgt, wr_tgt;
   logic [PEND_W-1:0] rd_cnt, wr_cnt;

   assign gnt_vld = (state == ST_GRANT);
   assign sel_req = (owner == RR_M1) ? m1_req : m0_req;
   assign sel_rnw = (owner == RR_M1) ? m1_rnw : m0_rnw;

   always_ff @(posedge clk_bus or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         owner   <= RR_M0;
         rr_prio <= RR_M0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_prio <= rr_nxt;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_prio;
      tc.req    = 1'b0;
      tc.rnw    = 1'b0;
      tc.addr   = '0;
      tc.wdata  = '0;
      m0_aack   = 1'b0;
      m1_aack   = 1'b0;
      case (state)
         ST_IDLE: begin
            // Full gating happens here only; pend_cnt cannot rise while a grant is open.
            if ((m0_req || m1_req) && (pend_cnt < MAX_C)) begin
               state_nxt = ST_GRANT;
               if (m0_req && m1_req) owner_nxt = rr_prio;
               else                  owner_nxt = m1_req ? RR_M1 : RR_M0;
            end
         end
         ST_GRANT: begin
            tc.req   = sel_req;
            tc.rnw   = sel_rnw;
            tc.addr  = (owner == RR_M1) ? m1_addr  : m0_addr;
            tc.wdata = (owner == RR_M1) ? m1_wdata : m0_wdata;
            m0_aack  = tc.aack && (owner == RR_M0);
            m1_aack  = tc.aack && (owner == RR_M1);
            if (tc.aack) begin
               state_nxt = ST_IDLE;
               rr_nxt    = ~owner;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rd_aack = gnt_vld && tc.aack && sel_rnw;
   assign wr_aack = gnt_vld && tc.aack && !sel_rnw;

   // A response with an empty queue may still belong to the address phase acked this cycle.
   assign rd_pop  = tc.rack && !rd_empty;
   assign rd_byp  = tc.rack && rd_empty && rd_aack;
   assign rd_push = rd_aack && !rd_byp;
   assign rd_hit  = rd_pop || rd_byp;
   assign rd_tgt  = rd_empty ? owner : rd_head;

   assign wr_pop  = tc.wack && !wr_empty;
   assign wr_byp  = tc.wack && wr_empty && wr_aack;
   assign wr_push = wr_aack && !wr_byp;
   assign wr_hit  = wr_pop || wr_byp;
   assign wr_tgt  = wr_empty ? owner : wr_head;

   assign m0_rack = rd_hit && (rd_tgt == RR_M0);
   assign m1_rack = rd_hit && (rd_tgt == RR_M1);
   assign m0_wack = wr_hit && (wr_tgt == RR_M0);
   assign m1_wack = wr_hit && (wr_tgt == RR_M1);

   tcbus_id_fifo #(.DEPTH(MAX_PEND)) u_rd_q (
      .clk   (clk_bus),
      .rst_n (rst_n),
      .push  (rd_push),
      .din   (owner),
      .pop   (rd_pop),
      .head  (rd_head),
      .empty (rd_empty),
      .count (rd_cnt)
   );

   tcbus_id_fifo #(.DEPTH(MAX_PEND)) u_wr_q (
      .clk   (clk_bus),
      .rst_n (rst_n),
      .push  (wr_push),
      .din   (owner),
      .pop   (wr_pop),
      .head  (wr_head),
      .empty (wr_empty),
      .count (wr_cnt)
   );

   assign pend_cnt = rd_cnt + wr_cnt;

   always_ff @(posedge clk_bus or negedge rst_n) begin
      if (!rst_n) begin
         proto_err <= 1'b0;
      end else if ((tc.rack && rd_empty && !rd_aack) || (tc.wack && wr_empty && !wr_aack)) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tcbus_arb2.sv
// Directed bench for tcbus_arb2: queue-based reference model checked every cycle plus literal expectations.
module tb_tcbus_arb2;
   import tcbus_pkg::*;

   localparam int MAXP = 4;

   logic       clk_bus = 1'b0;
   logic       rst_n   = 1'b0;
   logic       mreq  [2];
   logic       mrnw  [2];
   logic [7:0] maddr [2];
   logic [7:0] mwdata[2];
   logic       m_aack[2];
   logic       m_rack[2];
   logic       m_wack[2];
   logic [2:0] pend_cnt;
   logic       proto_err;

   int errors = 0;
   int checks = 0;

   always #5 clk_bus = ~clk_bus;

   tcbus_arb2_if #(.TC_AWIDTH(8), .TC_DWIDTH(8)) tc ();

   tcbus_arb2 #(.TC_AWIDTH(8), .TC_DWIDTH(8), .MAX_PEND(MAXP)) dut (
      .clk_bus   (clk_bus),
      .rst_n     (rst_n),
      .m0_req    (mreq[0]),
      .m0_rnw    (mrnw[0]),
      .m0_addr   (maddr[0]),
      .m0_wdata  (mwdata[0]),
      .m0_aack   (m_aack[0]),
      .m0_rack   (m_rack[0]),
      .m0_wack   (m_wack[0]),
      .m1_req    (mreq[1]),
      .m1_rnw    (mrnw[1]),
      .m1_addr   (maddr[1]),
      .m1_wdata  (mwdata[1]),
      .m1_aack   (m_aack[1]),
      .m1_rack   (m_rack[1]),
      .m1_wack   (m_wack[1]),
      .tc        (tc),
      .pend_cnt  (pend_cnt),
      .proto_err (proto_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bus ownership plus one FIFO of requester IDs per response type.
   bit gv, go, rr, merr;
   bit rq[$];
   bit wq[$];

   always @(negedge clk_bus) begin
      bit ack, rd_addr, wr_addr, r_v, r_t, w_v, w_t, r_q, w_q, e_req;
      int psum;
      if (!rst_n) begin
         gv = 0; go = 0; rr = 0; merr = 0;
         rq.delete();
         wq.delete();
      end else begin
         psum    = rq.size() + wq.size();
         e_req   = gv && mreq[go];
         ack     = gv && tc.aack;
         rd_addr = ack && mrnw[go];
         wr_addr = ack && !mrnw[go];
         r_v = 0; r_t = 0; r_q = 0; w_v = 0; w_t = 0; w_q = 0;
         if (tc.rack) begin
            if (rq.size() > 0) begin r_v = 1; r_t = rq[0]; r_q = 1; end
            else if (rd_addr)  begin r_v = 1; r_t = go; end
            else merr = merr;
         end
         if (tc.wack) begin
            if (wq.size() > 0) begin w_v = 1; w_t = wq[0]; w_q = 1; end
            else if (wr_addr)  begin w_v = 1; w_t = go; end
         end

         check("tc_req", tc.req, e_req);
         if (e_req) begin
            check("tc_rnw",   tc.rnw,   mrnw[go]);
            check("tc_addr",  tc.addr,  maddr[go]);
            check("tc_wdata", tc.wdata, mwdata[go]);
         end
         check("m0_aack", m_aack[0], ack && !go);
         check("m1_aack", m_aack[1], ack && go);
         check("m0_rack", m_rack[0], r_v && !r_t);
         check("m1_rack", m_rack[1], r_v && r_t);
         check("m0_wack", m_wack[0], w_v && !w_t);
         check("m1_wack", m_wack[1], w_v && w_t);
         check("pend_cnt", pend_cnt, psum);
         check("proto_err", proto_err, merr);

         if ((tc.rack && !r_v) || (tc.wack && !w_v)) merr = 1;
         if (r_q) void'(rq.pop_front());
         if (w_q) void'(wq.pop_front());
         if (rd_addr && !(r_v && !r_q)) rq.push_back(go);
         if (wr_addr && !(w_v && !w_q)) wq.push_back(go);
         if (gv) begin
            if (tc.aack) begin gv = 0; rr = !go; end
         end else if ((mreq[0] || mreq[1]) && psum < MAXP) begin
            gv = 1;
            go = (mreq[0] && mreq[1]) ? rr : mreq[1];
         end
      end
   end

   task automatic cyc();
      @(posedge clk_bus);
      #1;
   endtask

   task automatic req_on(input int m, input bit rnw, input logic [7:0] a, input logic [7:0] d);
      mreq[m] = 1; mrnw[m] = rnw; maddr[m] = a; mwdata[m] = d;
   endtask

   task automatic wait_tc_req();
      for (int i = 0; i < 20; i++) begin
         if (tc.req === 1'b1) return;
         cyc();
      end
      check("tc_req_timeout", tc.req, 1);
   endtask

   task automatic grant_ack(output int who);
      wait_tc_req();
      tc.aack = 1;
      #1;
      who = m_aack[1] ? 1 : (m_aack[0] ? 0 : -1);
      cyc();
      tc.aack = 0;
      if (who >= 0) mreq[who] = 0;
   endtask

   // Returns {m1_wack, m0_wack, m1_rack, m0_rack} seen during a one-cycle response pulse.
   task automatic rsp(input bit r, input bit w, output logic [3:0] seen);
      tc.rack = r;
      tc.wack = w;
      #1;
      seen = {m_wack[1], m_wack[0], m_rack[1], m_rack[0]};
      cyc();
      tc.rack = 0;
      tc.wack = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      tc.aack = 0; tc.rack = 0; tc.wack = 0;
      for (int i = 0; i < 2; i++) begin
         mreq[i] = 0; mrnw[i] = 0; maddr[i] = '0; mwdata[i] = '0;
      end
      cyc();
      cyc();
      rst_n = 1;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int who;
      logic [3:0] seen;

      do_reset();
      check("rst_pend", pend_cnt, 0);
      check("rst_tc_req", tc.req, 0);
      check("rst_err", proto_err, 0);

      // Single read from m0
      req_on(0, 1, 8'h12, 8'h00);
      cyc();
      check("s1_tc_req", tc.req, 1);
      check("s1_tc_addr", tc.addr, 8'h12);
      grant_ack(who);
      check("s1_owner", who, 0);
      check("s1_pend", pend_cnt, 1);
      cyc();
      cyc();
      rsp(1, 0, seen);
      check("s1_rack", seen, 4'b0001);
      check("s1_pend_after", pend_cnt, 0);

      // Simultaneous requests from reset, m0 re-requests straight away
      do_reset();
      req_on(0, 1, 8'h20, 8'h00);
      req_on(1, 1, 8'h21, 8'h00);
      grant_ack(who);
      check("s2_first", who, 0);
      req_on(0, 1, 8'h22, 8'h00);
      grant_ack(who);
      check("s2_second", who, 1);
      grant_ack(who);
      check("s2_third", who, 0);
      check("s2_pend", pend_cnt, 3);
      rsp(1, 0, seen); check("s2_rack0", seen, 4'b0001);
      rsp(1, 0, seen); check("s2_rack1", seen, 4'b0010);
      rsp(1, 0, seen); check("s2_rack2", seen, 4'b0001);

      // Write ordering interleaved with a read
      req_on(0, 0, 8'h30, 8'hA5);
      wait_tc_req();
      check("s3_wdata", tc.wdata, 8'hA5);
      check("s3_rnw", tc.rnw, 0);
      grant_ack(who);
      check("s3_w0", who, 0);
      req_on(1, 0, 8'h31, 8'h5A);
      grant_ack(who);
      check("s3_w1", who, 1);
      req_on(1, 1, 8'h32, 8'h00);
      grant_ack(who);
      check("s3_pend", pend_cnt, 3);
      rsp(0, 1, seen); check("s3_wack0", seen, 4'b0100);
      rsp(1, 1, seen); check("s3_wack1_rack", seen, 4'b1010);
      check("s3_pend_after", pend_cnt, 0);

      // Full at MAX_PEND reads
      for (int i = 0; i < MAXP; i++) begin
         req_on(0, 1, 8'h40 + 8'(i), 8'h00);
         grant_ack(who);
      end
      check("s4_pend_full", pend_cnt, 4);
      req_on(1, 1, 8'h50, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("s4_blocked", tc.req, 0);
      end
      rsp(1, 0, seen);
      check("s4_pop", seen, 4'b0001);
      check("s4_pend3", pend_cnt, 3);
      check("s4_not_yet", tc.req, 0);
      cyc();
      check("s4_granted", tc.req, 1);
      grant_ack(who);
      check("s4_owner", who, 1);
      for (int i = 0; i < 3; i++) begin
         rsp(1, 0, seen);
         check("s4_drain_m0", seen, 4'b0001);
      end
      rsp(1, 0, seen);
      check("s4_drain_m1", seen, 4'b0010);

      // Bypass with empty queue, then with m1 queued
      req_on(0, 1, 8'h60, 8'h00);
      wait_tc_req();
      tc.aack = 1; tc.rack = 1;
      #1;
      check("s5_aack", m_aack[0], 1);
      check("s5_rack", m_rack[0], 1);
      cyc();
      tc.aack = 0; tc.rack = 0; mreq[0] = 0;
      check("s5_pend", pend_cnt, 0);
      req_on(1, 1, 8'h61, 8'h00);
      grant_ack(who);
      check("s5_pend1", pend_cnt, 1);
      req_on(0, 1, 8'h62, 8'h00);
      wait_tc_req();
      tc.aack = 1; tc.rack = 1;
      #1;
      check("s5b_m1_rack", m_rack[1], 1);
      check("s5b_m0_rack", m_rack[0], 0);
      check("s5b_m0_aack", m_aack[0], 1);
      cyc();
      tc.aack = 0; tc.rack = 0; mreq[0] = 0;
      check("s5b_pend", pend_cnt, 1);
      rsp(1, 0, seen);
      check("s5b_rack_m0", seen, 4'b0001);

      // Unmatched write response
      rsp(0, 1, seen);
      check("s6_no_wack", seen, 4'b0000);
      check("s6_err", proto_err, 1);
      cyc(); cyc(); cyc();
      check("s6_err_sticky", proto_err, 1);

      // Reset with two transactions pending and a grant open
      req_on(0, 1, 8'h70, 8'h00);
      grant_ack(who);
      req_on(1, 0, 8'h71, 8'h33);
      grant_ack(who);
      check("s7_pend2", pend_cnt, 2);
      req_on(0, 1, 8'h72, 8'h00);
      wait_tc_req();
      #1;
      rst_n = 0;
      #1;
      check("s7_rst_req", tc.req, 0);
      check("s7_rst_pend", pend_cnt, 0);
      check("s7_rst_err", proto_err, 0);
      check("s7_rst_aack", {m_aack[1], m_aack[0]}, 2'b00);
      mreq[0] = 0; mreq[1] = 0;
      cyc();
      rst_n = 1;
      cyc();
      rsp(1, 0, seen);
      check("s7_orphan_rack", seen, 4'b0000);
      check("s7_err", proto_err, 1);

      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
